// File: rtl/updncnt_rpt_if.sv
// -----------------------------------------------------------------------------
// updncnt_rpt_if
// Groups the key inputs and counter outputs of the up/down repeat counter.
//   key_inc_n : increment key level, active-low, debounced and synchronised
//   key_dec_n : decrement key level, active-low, debounced and synchronised
//   cnt       : counter value, WIDTH bits
//   at_min    : high when cnt equals the lower bound
//   at_max    : high when cnt equals the upper bound
//   step      : one-cycle pulse in the cycle after cnt was stepped
// Modports: master drives the keys and observes the counter, slave is the
// counter itself.
// -----------------------------------------------------------------------------
interface updncnt_rpt_if #(
    parameter int WIDTH = 8
);
    logic             key_inc_n;
    logic             key_dec_n;
    logic [WIDTH-1:0] cnt;
    logic             at_min;
    logic             at_max;
    logic             step;

    modport master (
        output key_inc_n,
        output key_dec_n,
        input  cnt,
        input  at_min,
        input  at_max,
        input  step
    );

    modport slave (
        input  key_inc_n,
        input  key_dec_n,
        output cnt,
        output at_min,
        output at_max,
        output step
    );
endinterface

// File: rtl/updncnt_rpt.sv
// -----------------------------------------------------------------------------
// updncnt_rpt
// Bounded up/down counter driven directly by two active-low key levels, with
// press detection and hold-to-repeat. Feeds the PWM duty register of the LED
// dimmer.
// Ports:
//   clk  : clock, rising edge active
//   rst  : synchronous active-high reset
//   bus  : updncnt_rpt_if slave modport (key_inc_n, key_dec_n, cnt, at_min,
//          at_max, step)
// Build option:
//   UPDN_WRAP_EN undefined : steps saturate at MIN / MAX
//   UPDN_WRAP_EN defined   : steps wrap around inside [MIN, MAX]
// -----------------------------------------------------------------------------
module updncnt_rpt #(
    parameter int WIDTH       = 8,
    parameter int MIN         = 0,
    parameter int MAX         = 2**WIDTH - 1,
    parameter int INIT        = MIN,
    parameter int STEP        = 1,
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int RPT_CYCLES  = 5_000_000
) (
    input logic          clk,
    input logic          rst,
    updncnt_rpt_if.slave bus
);

    // Timer only ever holds HOLD_CYCLES-1 or RPT_CYCLES-1, size it for the larger.
    localparam int TMAX = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0]    HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]    RPT_LOAD  = TW'(RPT_CYCLES - 1);

    // One extra bit so cnt+STEP can never overflow before it is compared.
    localparam logic [WIDTH:0]   MIN_X  = (WIDTH+1)'(MIN);
    localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   ONE_X  = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RPT
    } state_t;

    state_t           state;
    logic [TW-1:0]    timer;
    logic             inc_q;
    logic             dec_q;
    logic             dir_inc;
    logic [WIDTH-1:0] cnt_q;
    logic             step_q;

    logic             inc_act;
    logic             dec_act;
    logic             inc_press;
    logic             dec_press;
    logic             held_act;
    logic [WIDTH:0]   cnt_x;
    logic [WIDTH:0]   inc_sum;
    logic [WIDTH:0]   dec_lim;
    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] dec_val;
    logic [WIDTH-1:0] press_val;

    // A key is active only when it is the single key held low. A press is an
    // active key whose previous sample was still released, so both-low and the
    // release of one key out of a both-low chord never look like a press.
    always_comb begin
        inc_act   = !bus.key_inc_n && bus.key_dec_n;
        dec_act   = bus.key_inc_n && !bus.key_dec_n;
        inc_press = inc_act && inc_q;
        dec_press = dec_act && dec_q;
        held_act  = dir_inc ? inc_act : dec_act;
    end

    // Next counter values for an increment and a decrement step.
    always_comb begin
        cnt_x   = {1'b0, cnt_q};
        inc_sum = cnt_x + STEP_X;
        dec_lim = MIN_X + STEP_X;
`ifdef UPDN_WRAP_EN
        inc_val = (inc_sum > MAX_X) ? WIDTH'(MIN_X + (inc_sum - MAX_X - ONE_X))
                                    : inc_sum[WIDTH-1:0];
        dec_val = (cnt_x < dec_lim) ? WIDTH'(MAX_X - (dec_lim - cnt_x - ONE_X))
                                    : WIDTH'(cnt_x - STEP_X);
`else
        inc_val = (inc_sum > MAX_X) ? MAX_W : inc_sum[WIDTH-1:0];
        dec_val = (cnt_x < dec_lim) ? MIN_W : WIDTH'(cnt_x - STEP_X);
`endif
        press_val = inc_press ? inc_val : dec_val;
    end

    // Press / hold / repeat state machine. A press steps immediately and arms
    // the long hold delay; once that expires the shorter repeat delay is used
    // for as long as the same key stays the only one held. In HOLD/RPT, a
    // release of the held key combined with a press of the other key restarts
    // the sequence for the new key.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            inc_q   <= 1'b1;
            dec_q   <= 1'b1;
            dir_inc <= 1'b0;
            cnt_q   <= INIT_W;
            step_q  <= 1'b0;
        end else begin
            inc_q  <= bus.key_inc_n;
            dec_q  <= bus.key_dec_n;
            step_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (inc_press || dec_press) begin
                        dir_inc <= inc_press;
                        cnt_q   <= press_val;
                        step_q  <= 1'b1;
                        timer   <= HOLD_LOAD;
                        state   <= HOLD;
                    end
                end
                HOLD, RPT: begin
                    if (held_act) begin
                        if (timer == '0) begin
                            cnt_q  <= dir_inc ? inc_val : dec_val;
                            step_q <= 1'b1;
                            timer  <= RPT_LOAD;
                            state  <= RPT;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end else if (inc_press || dec_press) begin
                        dir_inc <= inc_press;
                        cnt_q   <= press_val;
                        step_q  <= 1'b1;
                        timer   <= HOLD_LOAD;
                        state   <= HOLD;
                    end else begin
                        timer <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    timer <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cnt    = cnt_q;
    assign bus.step   = step_q;
    assign bus.at_min = (cnt_q == MIN_W);
    assign bus.at_max = (cnt_q == MAX_W);

endmodule
